// File: rtl/bus_init_pkg.sv
// bus_init_pkg: constants shared by the bus initiator and the peripherals it
// talks to.
//   ADDR_W / DATA_W : word address and data widths of the peripheral bus
//   ST_*            : bus_init FSM state encodings
//   cmd_t           : one captured command
//   bus_rdata       : response data selection (writes return zero)
package bus_init_pkg;

  localparam int ADDR_W = 30;
  localparam int DATA_W = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUS  = 2'd1;
  localparam logic [1:0] ST_RSP  = 2'd2;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  function automatic logic [DATA_W-1:0] bus_rdata(input logic we,
                                                  input logic [DATA_W-1:0] din);
    return we ? '0 : din;
  endfunction

endpackage

// File: rtl/bus_init_if.sv
// bus_init_if: peripheral bus between one initiator and its slaves.
//   stb      : strobe, initiator -> slave
//   we       : write enable, initiator -> slave
//   addr     : word address [31:2], initiator -> slave
//   data_out : write data, initiator -> slave
//   data_in  : read data, slave -> initiator
//   ack      : acknowledge, slave -> initiator (may be combinational from stb)
interface bus_init_if;
  import bus_init_pkg::*;

  logic              stb;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_out;
  logic [DATA_W-1:0] data_in;
  logic              ack;

  modport master (output stb, we, addr, data_out, input  data_in, ack);
  modport slave  (input  stb, we, addr, data_out, output data_in, ack);

endinterface

// File: rtl/bus_init_tmo.sv
// bus_init_tmo: bus-cycle timeout counter for bus_init.
//   clk, rst : clock, synchronous active-high reset
//   load     : restart the timeout window (start of a transfer)
//   en       : count one bus cycle
//   expired  : the window has run out
// Implemented as a down-counter loaded with TMO_CYCLES-1 that stops at zero,
// so it never wraps; expired is the terminal-count compare.
module bus_init_tmo #(
  parameter int TMO_CYCLES = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TMO_CYCLES + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(TMO_CYCLES - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_VAL;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/bus_init.sv
// bus_init: single-outstanding bus initiator. Converts a valid/ready command
// stream into one transfer on the peripheral bus and returns read data or an
// error on a response stream.
//   clk, rst                              : clock, synchronous active-high reset
//   cmd_valid/cmd_ready                   : command handshake
//   cmd_we, cmd_addr, cmd_wdata           : command payload
//   rsp_valid/rsp_ready                   : response handshake
//   rsp_rdata, rsp_err                    : response payload
//   bus                                   : bus_init_if master port
// Build option BUS_INIT_TIMEOUT_EN: when defined, a transfer without ack for
// TMO_CYCLES bus cycles ends with rsp_err = 1. When undefined the block waits
// for ack indefinitely and rsp_err is tied to 0.
//
// state | meaning
// ------+-------------------------------------------------
// IDLE  | ready for a command, bus idle
// BUS   | stb asserted, waiting for ack (or timeout)
// RSP   | response held until the consumer takes it
module bus_init
  import bus_init_pkg::*;
#(
  parameter int TMO_CYCLES = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  bus_init_if.master        bus
);

  if (TMO_CYCLES < 1 || TMO_CYCLES > 65535) begin : g_bad_tmo
    $error("bus_init: TMO_CYCLES out of range 1..65535");
  end

  logic [1:0] state;
  logic       accept;
  logic       tmo_expired;

  assign cmd_ready = (state == ST_IDLE);
  assign accept    = cmd_ready & cmd_valid;

`ifdef BUS_INIT_TIMEOUT_EN
  bus_init_tmo #(
    .TMO_CYCLES (TMO_CYCLES)
  ) u_tmo (
    .clk     (clk),
    .rst     (rst),
    .load    (accept),
    .en      (state == ST_BUS),
    .expired (tmo_expired)
  );

  // Error flag lives beside the FSM; ack beats a coincident timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_err <= 1'b0;
    end else if (accept) begin
      rsp_err <= 1'b0;
    end else if (state == ST_BUS) begin
      if (bus.ack) begin
        rsp_err <= 1'b0;
      end else if (tmo_expired) begin
        rsp_err <= 1'b1;
      end
    end
  end
`else
  assign tmo_expired = 1'b0;
  assign rsp_err     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      bus.stb      <= 1'b0;
      bus.we       <= 1'b0;
      bus.addr     <= '0;
      bus.data_out <= '0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            bus.we       <= cmd_we;
            bus.addr     <= cmd_addr;
            bus.data_out <= cmd_wdata;
            bus.stb      <= 1'b1;
            state        <= ST_BUS;
          end
        end
        ST_BUS: begin
          if (bus.ack) begin
            bus.stb   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= bus_rdata(bus.we, bus.data_in);
            state     <= ST_RSP;
          end else if (tmo_expired) begin
            bus.stb   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= '0;
            state     <= ST_RSP;
          end
        end
        ST_RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          bus.stb   <= 1'b0;
          rsp_valid <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
